// File: rtl/sc_pkg.sv
// -----------------------------------------------------------------------------
// sc_pkg
// Shared definitions for the stochastic-computing lane: controller state type,
// default operand width and stream length, and the stream-count width helper
// used by the controller's length counter and by the DRU.
// Optional feature macro used by this slice: SC_STREAM_CTRL_ABORT_EN.
// -----------------------------------------------------------------------------
package sc_pkg;

  localparam int SC_N_DEFAULT    = 4;
  localparam int SC_SLEN_DEFAULT = 15;

  typedef enum logic [2:0] {
    SC_IDLE  = 3'd0,
    SC_CLEAR = 3'd1,
    SC_RUN   = 3'd2,
    SC_DRAIN = 3'd3,
    SC_DONE  = 3'd4
  } sc_ctrl_state_t;

  // Bits needed to count 0..slen inclusive.
  function automatic int sc_cnt_width(input int slen);
    return (slen < 1) ? 1 : $clog2(slen + 1);
  endfunction

endpackage

// File: rtl/sc_stream_ctrl_if.sv
// -----------------------------------------------------------------------------
// sc_stream_ctrl_if
// Host-side operand and result handshakes of one stochastic-computing lane.
//   in_valid/in_ready/in_a/in_b     : operand pair from the host
//   out_valid/out_ready/out_res     : de-randomized result back to the host
// Modports: master = host side, slave = controller side.
// -----------------------------------------------------------------------------
interface sc_stream_ctrl_if #(
  parameter int N = sc_pkg::SC_N_DEFAULT
) ();

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_a;
  logic [N-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_res;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_res
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_res
  );

endinterface

// File: rtl/sc_len_counter.sv
// -----------------------------------------------------------------------------
// sc_len_counter
// Stream-length counter. Cleared by clr, advances by one while en is high,
// and flags tc when the count equals SLEN-1 (the last stream cycle).
// Ports: clk, rst (sync, active high), clr, en, tc.
// -----------------------------------------------------------------------------
module sc_len_counter
  import sc_pkg::*;
#(
  parameter int SLEN = SC_SLEN_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int            CW   = sc_cnt_width(SLEN);
  localparam logic [CW-1:0] LAST = CW'(SLEN - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear wins over enable.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = {CW{1'b0}};
    end else if (en) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == LAST);

endmodule

// File: rtl/sc_stream_ctrl.sv
// -----------------------------------------------------------------------------
// sc_stream_ctrl
// Sequencer for one stochastic-computing lane: accepts an operand pair, pulses
// sng_rst to clear the SNG LFSRs and DRU count, enables the stream for SLEN
// cycles, waits one drain cycle, captures dru_cnt and offers it on out_res.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   abort               (only with SC_STREAM_CTRL_ABORT_EN) drop current job
//   bus                 operand/result handshakes (slave modport)
//   sng_a, sng_b        held operands to the SNGs
//   sng_rst, sng_en     datapath clear pulse and stream enable
//   dru_cnt             DRU ones-count
//   busy                controller not in IDLE
// All control outputs are flops loaded from the next state, so none of them
// has a combinational path from an input.
// -----------------------------------------------------------------------------
module sc_stream_ctrl
  import sc_pkg::*;
#(
  parameter int N    = SC_N_DEFAULT,
  parameter int SLEN = SC_SLEN_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
`ifdef SC_STREAM_CTRL_ABORT_EN
  input  logic         abort,
`endif
  sc_stream_ctrl_if.slave bus,
  output logic [N-1:0] sng_a,
  output logic [N-1:0] sng_b,
  output logic         sng_rst,
  output logic         sng_en,
  input  logic [N-1:0] dru_cnt,
  output logic         busy
);

  sc_ctrl_state_t state_q, state_d;
  logic [N-1:0]   sng_a_q, sng_a_d;
  logic [N-1:0]   sng_b_q, sng_b_d;
  logic [N-1:0]   out_res_q, out_res_d;
  logic           in_ready_q, busy_q, sng_en_q, sng_rst_q, out_valid_q;
  logic           abort_s;
  logic           tc_s;

`ifdef SC_STREAM_CTRL_ABORT_EN
  assign abort_s = abort;
`else
  assign abort_s = 1'b0;
`endif

  sc_len_counter #(.SLEN(SLEN)) u_len_counter (
    .clk (clk),
    .rst (rst),
    .clr (state_q == SC_CLEAR),
    .en  (state_q == SC_RUN),
    .tc  (tc_s)
  );

  // Next state, operand latch and result capture.
  always_comb begin
    state_d   = state_q;
    sng_a_d   = sng_a_q;
    sng_b_d   = sng_b_q;
    out_res_d = out_res_q;
    case (state_q)
      SC_IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          sng_a_d = bus.in_a;
          sng_b_d = bus.in_b;
          state_d = SC_CLEAR;
        end else begin
          state_d = SC_IDLE;
        end
      end
      SC_CLEAR: begin
        if (abort_s) begin
          state_d = SC_IDLE;
        end else begin
          state_d = SC_RUN;
        end
      end
      SC_RUN: begin
        if (abort_s) begin
          state_d = SC_IDLE;
        end else if (tc_s) begin
          state_d = SC_DRAIN;
        end else begin
          state_d = SC_RUN;
        end
      end
      SC_DRAIN: begin
        // The DRU has absorbed the final stream bit by the end of this cycle.
        if (abort_s) begin
          state_d = SC_IDLE;
        end else begin
          out_res_d = dru_cnt;
          state_d   = SC_DONE;
        end
      end
      SC_DONE: begin
        if (bus.out_ready) begin
          state_d = SC_IDLE;
        end else begin
          state_d = SC_DONE;
        end
      end
      default: begin
        state_d = SC_IDLE;
      end
    endcase
  end

  // State, datapath holds and next-state-decoded control outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SC_IDLE;
      sng_a_q     <= {N{1'b0}};
      sng_b_q     <= {N{1'b0}};
      out_res_q   <= {N{1'b0}};
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      sng_en_q    <= 1'b0;
      sng_rst_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sng_a_q     <= sng_a_d;
      sng_b_q     <= sng_b_d;
      out_res_q   <= out_res_d;
      in_ready_q  <= (state_d == SC_IDLE);
      busy_q      <= (state_d != SC_IDLE);
      sng_en_q    <= (state_d == SC_RUN);
      sng_rst_q   <= (state_d == SC_CLEAR);
      out_valid_q <= (state_d == SC_DONE);
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_res   = out_res_q;
  assign sng_a         = sng_a_q;
  assign sng_b         = sng_b_q;
  assign sng_rst       = sng_rst_q;
  assign sng_en        = sng_en_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_sc_stream_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sc_stream_ctrl
// Directed bench for sc_stream_ctrl. A job-timeline model (phase since
// accept) predicts every output each cycle; literal checks pin the timeline.
// -----------------------------------------------------------------------------
module tb_sc_stream_ctrl;

  localparam int N    = 4;
  localparam int SLEN = 15;

  logic         clk;
  logic         rst;
  logic [N-1:0] sng_a, sng_b, dru_cnt;
  logic         sng_rst, sng_en, busy;
`ifdef SC_STREAM_CTRL_ABORT_EN
  logic         abort;
`endif

  sc_stream_ctrl_if #(.N(N)) bus ();

  sc_stream_ctrl #(.N(N), .SLEN(SLEN)) dut (
    .clk     (clk),
    .rst     (rst),
`ifdef SC_STREAM_CTRL_ABORT_EN
    .abort   (abort),
`endif
    .bus     (bus.slave),
    .sng_a   (sng_a),
    .sng_b   (sng_b),
    .sng_rst (sng_rst),
    .sng_en  (sng_en),
    .dru_cnt (dru_cnt),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- model: job phase counted from the accept edge ----------
  // ph<0 idle; 1 clear; 2..SLEN+1 stream; SLEN+2 drain; >=SLEN+3 result held.
  int           cyc = 0;
  int           m_ph = -1;
  bit           m_ready = 1'b0;
  logic [N-1:0] m_a = '0, m_b = '0, m_res = '0;
  bit           m_abort;

  int           n_acc = 0;
  int           acc_last = 0;
  logic [N-1:0] res_q[$];

  // Model update plus accept/result logging on each rising edge.
  always @(posedge clk) begin
    cyc = cyc + 1;
`ifdef SC_STREAM_CTRL_ABORT_EN
    m_abort = (abort === 1'b1);
`else
    m_abort = 1'b0;
`endif
    if (!rst && bus.in_valid && bus.in_ready) begin
      n_acc++;
      acc_last = cyc;
    end
    if (!rst && bus.out_valid && bus.out_ready) res_q.push_back(bus.out_res);
    if (rst) begin
      m_ph = -1; m_ready = 1'b0; m_a = '0; m_b = '0; m_res = '0;
    end else begin
      if (m_ph < 0) begin
        if (bus.in_valid && m_ready) begin
          m_ph = 1; m_a = bus.in_a; m_b = bus.in_b;
        end
      end else if (m_ph >= SLEN + 3) begin
        if (bus.out_ready) m_ph = -1;
      end else if (m_abort) begin
        m_ph = -1;
      end else begin
        if (m_ph == SLEN + 2) m_res = dru_cnt;
        m_ph = m_ph + 1;
      end
      m_ready = (m_ph < 0);
    end
  end

  // ---------------- DRU stub and compare process ---------------------------
  logic [N-1:0] job_val = '0;
  int n_en = 0, n_rst = 0, n_ovc = 0;

  // Compare on the falling edge; stub presents job_val only during drain.
  always @(negedge clk) begin
    if (busy === 1'b1 && sng_en === 1'b0 && sng_rst === 1'b0 && bus.out_valid === 1'b0)
      dru_cnt = job_val;
    else
      dru_cnt = ~job_val;
    if (sng_en === 1'b1) n_en++;
    if (sng_rst === 1'b1) n_rst++;
    if (bus.out_valid === 1'b1) n_ovc++;
    if (chk_en) begin
      check("in_ready",  32'(bus.in_ready),  32'(m_ready));
      check("busy",      32'(busy),          32'(m_ph >= 1));
      check("sng_rst",   32'(sng_rst),       32'(m_ph == 1));
      check("sng_en",    32'(sng_en),        32'(m_ph >= 2 && m_ph <= SLEN + 1));
      check("out_valid", 32'(bus.out_valid), 32'(m_ph >= SLEN + 3));
      check("out_res",   32'(bus.out_res),   32'(m_res));
      check("sng_a",     32'(sng_a),         32'(m_a));
      check("sng_b",     32'(sng_b),         32'(m_b));
    end
  end

  // ---------------- stimulus helpers ---------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_for_ov(input int bound);
    int i;
    i = 0;
    while (bus.out_valid !== 1'b1 && i < bound) begin
      step();
      i++;
    end
    check("wait_out_valid", 32'(bus.out_valid), 32'd1);
  endtask

  task automatic send(input logic [N-1:0] a, input logic [N-1:0] b, input logic [N-1:0] v);
    int a0;
    a0 = n_acc;
    bus.in_a = a; bus.in_b = b; bus.in_valid = 1'b1;
    job_val = v;
    step();
    bus.in_valid = 1'b0;
    check("accept", 32'(n_acc - a0), 32'd1);
  endtask

  int e0, r0, o0, k1, k2, qn, a0;

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b0;
`ifdef SC_STREAM_CTRL_ABORT_EN
    abort = 1'b0;
`endif
    step();
    chk_en = 1'b1;
    step(); step();
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    rst = 1'b0;
    step(); step();

    // Job 1: (5,3), result 9, consumer ready.
    bus.out_ready = 1'b1;
    e0 = n_en; r0 = n_rst; o0 = n_ovc; qn = res_q.size();
    send(4'd5, 4'd3, 4'd9);
    k1 = acc_last;
    wait_for_ov(40);
    check("ov_latency", 32'(cyc + 1 - k1), 32'd18);
    step();
    check("ready_after_hs", 32'(bus.in_ready), 32'd1);
    step();
    check("sng_en_cycles",  32'(n_en - e0),  32'd15);
    check("sng_rst_cycles", 32'(n_rst - r0), 32'd1);
    check("ov_cycles",      32'(n_ovc - o0), 32'd1);
    check("res_count1",     32'(res_q.size() - qn), 32'd1);
    if (res_q.size() > 0) check("res_job1", 32'(res_q[res_q.size()-1]), 32'd9);

    // Job 2: (7,2), result 6, consumer stalls 20 cycles with stray in_valid.
    bus.out_ready = 1'b0;
    send(4'd7, 4'd2, 4'd6);
    wait_for_ov(40);
    for (int i = 0; i < 20; i++) begin
      bus.in_valid = i[0];
      bus.in_a = 4'(i); bus.in_b = 4'(15 - i);
      step();
    end
    bus.in_valid = 1'b0;
    check("stall_busy", 32'(busy), 32'd1);
    check("stall_ov",   32'(bus.out_valid), 32'd1);
    check("stall_res",  32'(bus.out_res), 32'd6);
    check("stall_sng_a", 32'(sng_a), 32'd7);
    bus.out_ready = 1'b1;
    step();
    check("stall_release_ready", 32'(bus.in_ready), 32'd1);
    step();

    // Jobs 3/4 back to back: (5,3)->9 then (12,7)->11.
    qn = res_q.size();
    a0 = n_acc;
    k1 = 0; k2 = 0;
    bus.in_a = 4'd5; bus.in_b = 4'd3; bus.in_valid = 1'b1; job_val = 4'd9;
    for (int i = 0; i < 60 && n_acc < a0 + 2; i++) begin
      step();
      if (n_acc == a0 + 1 && k1 == 0) begin
        k1 = acc_last;
        bus.in_a = 4'd12; bus.in_b = 4'd7;
      end
    end
    k2 = acc_last;
    bus.in_valid = 1'b0;
    job_val = 4'd11;
    check("b2b_accepts", 32'(n_acc - a0), 32'd2);
    check("b2b_gap", 32'(k2 - k1), 32'd19);
    wait_for_ov(40);
    step(); step();
    check("b2b_results", 32'(res_q.size() - qn), 32'd2);
    if (res_q.size() >= 2) begin
      check("b2b_res_first",  32'(res_q[res_q.size()-2]), 32'd9);
      check("b2b_res_second", 32'(res_q[res_q.size()-1]), 32'd11);
    end

    // Reset in the 7th stream cycle, then a fresh job.
    o0 = n_ovc; qn = res_q.size();
    send(4'd4, 4'd4, 4'd3);
    for (int i = 0; i < 7; i++) step();
    check("pre_rst_sng_en", 32'(sng_en), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_sng_en", 32'(sng_en), 32'd0);
    check("rst_busy",   32'(busy), 32'd0);
    check("rst_sng_a",  32'(sng_a), 32'd0);
    for (int i = 0; i < 25; i++) step();
    check("rst_no_ov", 32'(n_ovc - o0), 32'd0);
    send(4'd9, 4'd1, 4'd13);
    wait_for_ov(40);
    step(); step();
    check("fresh_results", 32'(res_q.size() - qn), 32'd1);
    if (res_q.size() > 0) check("fresh_res", 32'(res_q[res_q.size()-1]), 32'd13);

`ifdef SC_STREAM_CTRL_ABORT_EN
    // Abort mid-stream, then abort while the result is held.
    o0 = n_ovc;
    send(4'd3, 4'd3, 4'd5);
    for (int i = 0; i < 4; i++) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_busy",   32'(busy), 32'd0);
    check("abort_sng_en", 32'(sng_en), 32'd0);
    for (int i = 0; i < 25; i++) step();
    check("abort_no_ov", 32'(n_ovc - o0), 32'd0);
    bus.out_ready = 1'b0;
    send(4'd2, 4'd2, 4'd4);
    wait_for_ov(40);
    abort = 1'b1;
    step(); step();
    abort = 1'b0;
    check("abort_done_ov",  32'(bus.out_valid), 32'd1);
    check("abort_done_res", 32'(bus.out_res), 32'd4);
    bus.out_ready = 1'b1;
    step(); step();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/sc_stream_ctrl.md
# sc_stream_ctrl

Sequencer for one stochastic-computing lane. It owns a pair of SNGs and the DRU that follows them: it accepts an operand pair, clears the LFSRs and the DRU count, and runs the bitstream for a fixed stream length. It then captures the de-randomized count and returns it over a valid/ready handshake. It sits between the host-side operand source and the sng/dru datapath.

## Interface
Parameters:
- N, 4, operand/result width; matches SNG and DRU width.
- SLEN, 15, stream length in clock cycles; legal range 1 .. 2^N-1 (one full LFSR period by default).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  controller can accept operands.
- in_a  in  N  operand A, sampled on accept.
- in_b  in  N  operand B, sampled on accept.
- sng_a  out  N  held operand to SNG A.
- sng_b  out  N  held operand to SNG B.
- sng_rst  out  1  one-cycle clear pulse to SNG LFSRs and DRU counter.
- sng_en  out  1  stream enable; high for exactly SLEN cycles per job.
- dru_cnt  in  N  DRU ones-count.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumer ready.
- out_res  out  N  captured DRU count.
- busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, CLEAR, RUN, DRAIN, DONE. Reset state is IDLE.
- IDLE: in_ready=1. On in_valid: latch in_a/in_b into sng_a/sng_b, then go to CLEAR.
- CLEAR: sng_rst=1 for one cycle; clear stream counter; go to RUN.
- RUN: sng_en=1; counter increments every cycle. When counter==SLEN-1, go to DRAIN.
- DRAIN: sng_en=0. One cycle for the DRU register to absorb the last stream bit. On exit, capture out_res<=dru_cnt. Go to DONE.
- DONE: out_valid=1; out_res and sng_a/sng_b held. On out_ready, go to IDLE.
- sng_a/sng_b only change on accept; they are stable from CLEAR through DONE.
- Count width is clog2(SLEN+1). SLEN ≤ 2^N-1, so dru_cnt never overflows N bits and no saturation is needed.
- in_valid outside IDLE is ignored; in_ready=0 guarantees no accept.
- out_ready outside DONE is ignored.

## Timing
- Reset values: sng_a=0, sng_b=0, out_res=0, counter=0, sng_rst=0, sng_en=0, out_valid=0, busy=0. in_ready=0 while rst=1, and 1 from the first cycle after rst deasserts.
- Accept at edge k. Then:
  - CLEAR during cycle k+1.
  - RUN during cycles k+2 .. k+1+SLEN.
  - DRAIN during cycle k+2+SLEN.
  - out_valid first high in cycle k+3+SLEN.
- Minimum job-to-job period is SLEN+4 cycles: a new accept is possible the cycle after the out_valid&out_ready handshake.
- Back-to-back: a result accepted at edge j gives in_ready=1 in cycle j+1.
- rst mid-job, in any state: next cycle is IDLE with reset values. sng_rst is not pulsed; the next job's CLEAR clears the datapath.
- The outputs in_ready, busy, sng_en, sng_rst and out_valid decode from registered state with no input-to-output combinational path.

## Configuration
- Macro SC_STREAM_CTRL_ABORT_EN.
- Defined: adds input port abort (1 bit). abort=1 in CLEAR, RUN or DRAIN causes:
  - next state IDLE;
  - sng_en=0 next cycle;
  - no out_res capture and no out_valid.
- abort in IDLE or DONE is ignored. rst has priority over abort.
- Undefined: no abort port; every accepted job runs to DONE.

## Structure
- Shared package sc_pkg holds:
  - the state enum type sc_ctrl_state_t;
  - the default stream-length constant SC_SLEN_DEFAULT;
  - the count-width helper (clog2-based) used by controller and DRU.
- One sub-module, sc_len_counter: clear, enable, terminal-count flag at SLEN-1, parameterised by SLEN.

## Test plan
- Reset, then A=5, B=3 with in_valid for one cycle:
  - in_ready drops the next cycle;
  - sng_rst is high for exactly 1 cycle;
  - sng_en is high for exactly 15 cycles;
  - out_valid rises 18 cycles after accept;
  - sng_a=5, sng_b=3 are held throughout.
- DRU stub drives dru_cnt=9 during DRAIN, out_ready=1 -> out_res=9, out_valid is high for 1 cycle, in_ready=1 the next cycle.
- out_ready held low for 20 cycles in DONE -> out_valid and out_res stay stable, busy=1, in_valid pulses ignored. Releasing out_ready -> IDLE.
- Two jobs back-to-back, (5,3) then (12,7), with out_ready=1 -> second accept exactly 19 cycles after the first, and both results are captured in order.
- rst asserted in the 7th RUN cycle -> sng_en=0 and busy=0 the next cycle, no out_valid, and a fresh job then completes normally.
- With SC_STREAM_CTRL_ABORT_EN: abort in RUN -> IDLE next cycle, out_valid never asserts. abort in DONE -> ignored.
